vx_ifetch_rsp_ibuffer: RTL and testbench

// - Per-warp instruction buffer between the ifetch response channel and decode.
// - Accepts fetched instructions tagged by warp id into one FIFO per warp.
// - Drains the FIFOs to decode through a round-robin arbiter.
// - Signals each dequeue back to the warp scheduler as a one-hot per-warp ibuf_pop credit pulse.

---
 rtl/vx_ifetch_rsp_ibuffer.sv | 139 +++++++++++++
 tb/tb_vx_ifetch_rsp_ibuffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_ifetch_rsp_ibuffer.sv
// rtl/vx_ifetch_rsp_ibuffer.sv - per-warp instruction buffer with round-robin drain (optional IBUF_BYPASS_EN)
module vx_ifetch_rsp_ibuffer #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_BITS   = 44,
  parameter int DEPTH       = 2,
  localparam int WB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int UB = (UUID_BITS > 0) ? UUID_BITS : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [UB-1:0]          in_uuid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [WB-1:0]          in_wid,
  input  logic [XLEN-1:0]        in_PC,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [UB-1:0]          out_uuid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [WB-1:0]          out_wid,
  output logic [XLEN-1:0]        out_PC,
  output logic [31:0]            out_data,
  input  logic                   out_ready,
  output logic [NUM_WARPS-1:0]   ibuf_pop
);

  localparam int CB = $clog2(DEPTH + 1);
  localparam int PB = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = UB + NUM_THREADS + XLEN + 32;

  logic [CB-1:0] count  [NUM_WARPS];
  logic [PB-1:0] rd_ptr [NUM_WARPS];
  logic [PB-1:0] wr_ptr [NUM_WARPS];
  logic [EW-1:0] mem    [NUM_WARPS][DEPTH];

  logic [WB-1:0]        rr_ptr;
  logic [WB-1:0]        rr_grant;
  logic [WB-1:0]        grant;
  logic [WB-1:0]        lock_wid;
  logic                 locked;
  logic                 any_valid;
  logic [WB:0]          cand;
  logic [EW-1:0]        head;
  logic [EW-1:0]        in_entry;
  logic                 bypass;
  logic                 out_fire;
  logic                 enq_fire;
  logic                 deq_fire;
  logic [WB-1:0]        next_rr;
  logic [NUM_WARPS-1:0] enq_sel;
  logic [NUM_WARPS-1:0] deq_sel;

  function automatic logic [PB-1:0] ptr_inc(input logic [PB-1:0] p);
    return (p == PB'(DEPTH - 1)) ? '0 : p + PB'(1);
  endfunction

  // Round-robin search: first nonempty warp at or after rr_ptr, wrapping.
  always_comb begin
    any_valid = 1'b0;
    rr_grant  = rr_ptr;
    cand      = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand = {1'b0, rr_ptr} + (WB + 1)'(i);
      if (cand >= (WB + 1)'(NUM_WARPS)) cand = cand - (WB + 1)'(NUM_WARPS);
      if (!any_valid && count[cand[WB-1:0]] != '0) begin
        any_valid = 1'b1;
        rr_grant  = cand[WB-1:0];
      end
    end
  end

  // A stalled output keeps its grant so the presented entry cannot change under decode.
  assign grant    = locked ? lock_wid : rr_grant;
  assign head     = mem[grant][rd_ptr[grant]];
  assign in_entry = {in_uuid, in_tmask, in_PC, in_data};

`ifdef IBUF_BYPASS_EN
  // With every FIFO empty the incoming instruction goes straight to decode.
  assign bypass    = ~any_valid & in_valid;
  assign out_valid = any_valid | bypass;
  assign out_wid   = bypass ? in_wid : grant;
  assign {out_uuid, out_tmask, out_PC, out_data} = bypass ? in_entry : head;
`else
  assign bypass    = 1'b0;
  assign out_valid = any_valid;
  assign out_wid   = grant;
  assign {out_uuid, out_tmask, out_PC, out_data} = head;
`endif

  // Space check uses the count before any same-cycle pop, keeping in_ready off the out_ready path.
  assign in_ready = (count[in_wid] < CB'(DEPTH));
  assign out_fire = out_valid & out_ready;
  assign deq_fire = out_fire & ~bypass;
  assign enq_fire = in_valid & in_ready & ~(bypass & out_ready);
  assign ibuf_pop = out_fire ? (NUM_WARPS'(1) << out_wid) : '0;
  assign next_rr  = (out_wid == WB'(NUM_WARPS - 1)) ? '0 : out_wid + WB'(1);

  // Decode which warp FIFO is written and which is read this cycle.
  always_comb begin
    enq_sel = '0;
    deq_sel = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      enq_sel[w] = enq_fire & (in_wid == WB'(w));
      deq_sel[w] = deq_fire & (grant == WB'(w));
    end
  end

  // Pointer, occupancy, round-robin and grant-lock state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_wid <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (enq_sel[w]) wr_ptr[w] <= ptr_inc(wr_ptr[w]);
        if (deq_sel[w]) rd_ptr[w] <= ptr_inc(rd_ptr[w]);
        count[w] <= count[w] + CB'(enq_sel[w]) - CB'(deq_sel[w]);
      end
      if (out_fire) rr_ptr <= next_rr;
      locked   <= out_valid & ~out_ready;
      lock_wid <= out_wid;
    end
  end

  // Entry storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[in_wid][wr_ptr[in_wid]] <= in_entry;
  end

endmodule

// File: tb/tb_vx_ifetch_rsp_ibuffer.sv
// tb/tb_vx_ifetch_rsp_ibuffer.sv - directed self-checking bench for vx_ifetch_rsp_ibuffer
module tb_vx_ifetch_rsp_ibuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [43:0] in_uuid;
  logic [3:0]  in_tmask;
  logic [1:0]  in_wid;
  logic [31:0] in_PC;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [43:0] out_uuid;
  logic [3:0]  out_tmask;
  logic [1:0]  out_wid;
  logic [31:0] out_PC;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  ibuf_pop;

  int checks = 0;
  int errors = 0;

  vx_ifetch_rsp_ibuffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_uuid   (in_uuid),
    .in_tmask  (in_tmask),
    .in_wid    (in_wid),
    .in_PC     (in_PC),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_uuid  (out_uuid),
    .out_tmask (out_tmask),
    .out_wid   (out_wid),
    .out_PC    (out_PC),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ibuf_pop  (ibuf_pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wid, input logic [31:0] pc);
    in_valid = v;
    in_wid   = wid;
    in_PC    = pc;
    in_data  = pc ^ 32'hDEAD_0000;
    in_uuid  = {12'h0, pc};
    in_tmask = 4'hF;
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h50);

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ibuf_pop", ibuf_pop, 4'b0000);
      chk("rst_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 2'd2, 32'h50);
    reset = 1'b1;
    tick();
    chk("post_rst_empty", out_valid, 1'b0);

    // Fill warp 2 with out_ready low.
    drive(1'b1, 2'd2, 32'h100);
    chk("fill_rdy0", in_ready, 1'b1);
    chk("fill_lat0", out_valid, 1'b0);
    tick();
    drive(1'b1, 2'd2, 32'h104);
    chk("fill_valid1", out_valid, 1'b1);
    chk("fill_rdy1", in_ready, 1'b1);
    tick();
    drive(1'b0, 2'd2, 32'h0);
    chk("full_rdy_w2", in_ready, 1'b0);
    in_wid = 2'd0; #1;
    chk("full_rdy_w0", in_ready, 1'b1);
    chk("full_out_wid", out_wid, 2'd2);
    chk("full_pop_idle", ibuf_pop, 4'b0000);
    out_ready = 1'b1; #1;
    chk("drain0_pc", out_PC, 32'h100);
    chk("drain0_data", out_data, 32'hDEAD_0100);
    chk("drain0_pop", ibuf_pop, 4'b0100);
    tick();
    chk("drain1_pc", out_PC, 32'h104);
    chk("drain1_pop", ibuf_pop, 4'b0100);
    tick();
    out_ready = 1'b0; #1;
    chk("drain_empty", out_valid, 1'b0);

    // Round robin over warps 0,1,3.
    drive(1'b1, 2'd0, 32'h200); tick();
    drive(1'b1, 2'd1, 32'h210); tick();
    drive(1'b1, 2'd3, 32'h230); tick();
    drive(1'b0, 2'd0, 32'h0);
    out_ready = 1'b1; #1;
    chk("rr0_wid", out_wid, 2'd0);
    chk("rr0_pop", ibuf_pop, 4'b0001);
    chk("rr0_pc", out_PC, 32'h200);
    tick();
    chk("rr1_wid", out_wid, 2'd1);
    chk("rr1_pop", ibuf_pop, 4'b0010);
    chk("rr1_pc", out_PC, 32'h210);
    tick();
    chk("rr3_wid", out_wid, 2'd3);
    chk("rr3_pop", ibuf_pop, 4'b1000);
    chk("rr3_pc", out_PC, 32'h230);
    tick();
    out_ready = 1'b0; #1;
    chk("rr_empty", out_valid, 1'b0);

    // Stall lock: warp 1 presented while warp 0 fills.
    drive(1'b1, 2'd1, 32'h300); tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b1, 2'd0, 32'h310 + 32'(4 * i));
      else       drive(1'b0, 2'd0, 32'h0);
      chk("lock_wid", out_wid, 2'd1);
      chk("lock_pc", out_PC, 32'h300);
      chk("lock_pop", ibuf_pop, 4'b0000);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("lock_rel_wid", out_wid, 2'd1);
    chk("lock_rel_pop", ibuf_pop, 4'b0010);
    tick();
    chk("lock_w0a_wid", out_wid, 2'd0);
    chk("lock_w0a_pc", out_PC, 32'h310);
    tick();
    chk("lock_w0b_pc", out_PC, 32'h314);
    chk("lock_w0b_pop", ibuf_pop, 4'b0001);
    tick();
    out_ready = 1'b0; #1;
    chk("lock_empty", out_valid, 1'b0);

    // Same-warp enqueue+dequeue at count 1, pointers wrapping.
    drive(1'b1, 2'd2, 32'h400); tick();
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 2'd2, 32'h400 + 32'(4 * i));
      chk("sw_rdy", in_ready, 1'b1);
      chk("sw_pc", out_PC, 32'h400 + 32'(4 * (i - 1)));
      chk("sw_pop", ibuf_pop, 4'b0100);
      tick();
    end
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h414); tick();
    drive(1'b0, 2'd2, 32'h0);
    chk("sw_count2_full", in_ready, 1'b0);
    out_ready = 1'b1; #1;
    chk("sw_tail0_pc", out_PC, 32'h410);
    tick();
    chk("sw_tail1_pc", out_PC, 32'h414);
    tick();
    chk("sw_empty", out_valid, 1'b0);

    // Without bypass an empty buffer never presents the input in the same cycle.
    drive(1'b1, 2'd3, 32'h500);
    chk("nobyp_same_cycle", out_valid, 1'b0);
    chk("nobyp_pop", ibuf_pop, 4'b0000);
    tick();
    drive(1'b0, 2'd3, 32'h0);
    chk("nobyp_next_valid", out_valid, 1'b1);
    chk("nobyp_next_wid", out_wid, 2'd3);
    chk("nobyp_next_pop", ibuf_pop, 4'b1000);
    tick();
    chk("nobyp_empty", out_valid, 1'b0);

    // Reset mid-operation discards buffered entries.
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 32'h600); tick();
    drive(1'b0, 2'd1, 32'h0);
    chk("midrst_pre_valid", out_valid, 1'b1);
    reset = 1'b0;
    tick();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_rdy", in_ready, 1'b1);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_after_valid", out_valid, 1'b0);
    chk("midrst_after_pop", ibuf_pop, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
